// File: rtl/iq_alloc.sv
// Issue-queue entry allocator: hands out the lowest-index free entries to the
// rename slots, tags each one with a rolling age, and reclaims entries on issue grants.

module iq_alloc_slot #(
  parameter int CIQ_DEPTH = 16,
  parameter int IDX_WIDTH = 4,
  parameter int CW        = 5
) (
  input  logic [CIQ_DEPTH-1:0] busy_i,
  input  logic [CW-1:0]        rank_i,
  output logic [IDX_WIDTH-1:0] addr_o
);
  logic [CW-1:0] seen;

  // The slot with rank r takes the r-th free entry in ascending index order.
  always_comb begin
    addr_o = '0;
    seen   = '0;
    for (int e = 0; e < CIQ_DEPTH; e++) begin
      if (!busy_i[e]) begin
        if (seen == rank_i) addr_o = IDX_WIDTH'(e);
        seen = seen + CW'(1);
      end
    end
  end
endmodule

module iq_alloc #(
  parameter int DECODE_NUM = 4,
  parameter int ISSUE_NUM  = 4,
  parameter int CIQ_DEPTH  = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int AGE        = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [DECODE_NUM-1:0]                dispatch_valid,
  output logic                                 dispatch_ready,
  output logic [DECODE_NUM-1:0][IDX_WIDTH-1:0] free_addr,
  output logic [DECODE_NUM-1:0]                free_valid,
  output logic [DECODE_NUM-1:0][AGE-1:0]       age,
  input  logic [ISSUE_NUM-1:0][IDX_WIDTH-1:0]  arbit_addr,
  input  logic [ISSUE_NUM-1:0]                 arbit_grant,
  output logic [IDX_WIDTH:0]                   free_count,
  output logic                                 iq_full,
  output logic                                 err_double_free
);
  localparam int CW = IDX_WIDTH + 1;

  logic [CIQ_DEPTH-1:0]                 busy_q, busy_d, alloc, rel;
  logic [CW-1:0]                        free_q, free_d, n_req;
  logic [AGE-1:0]                       age_q, age_d;
  logic                                 err_q, err_d, dbl;
  logic [DECODE_NUM-1:0][CW-1:0]        rank;
  logic [DECODE_NUM-1:0][IDX_WIDTH-1:0] pick;

  always_comb begin
    n_req = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      rank[i] = n_req;
      n_req   = n_req + CW'(dispatch_valid[i]);
    end
  end

  assign dispatch_ready = (n_req <= free_q) && !flush && rst_n;

  for (genvar g = 0; g < DECODE_NUM; g++) begin : g_slot
    iq_alloc_slot #(
      .CIQ_DEPTH(CIQ_DEPTH), .IDX_WIDTH(IDX_WIDTH), .CW(CW)
    ) u_slot (
      .busy_i(busy_q), .rank_i(rank[g]), .addr_o(pick[g])
    );
    assign free_valid[g] = dispatch_valid[g] & dispatch_ready;
    assign free_addr[g]  = free_valid[g] ? pick[g] : '0;
    assign age[g]        = free_valid[g] ? age_q + AGE'(rank[g]) : '0;
  end

  // Double-free is judged against start-of-cycle busy, so duplicates don't self-trigger.
  always_comb begin
    rel = '0;
    dbl = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (arbit_grant[j] && int'(arbit_addr[j]) < CIQ_DEPTH) begin
        rel[arbit_addr[j]] = 1'b1;
        if (!busy_q[arbit_addr[j]]) dbl = 1'b1;
      end
    end
  end

  always_comb begin
    alloc = '0;
    for (int i = 0; i < DECODE_NUM; i++)
      if (free_valid[i]) alloc[pick[i]] = 1'b1;
  end

  always_comb begin
    busy_d = (busy_q & ~rel) | alloc;
    age_d  = dispatch_ready ? age_q + AGE'(n_req) : age_q;
    err_d  = err_q | dbl;
    if (flush) begin
      busy_d = '0;
      age_d  = '0;
      err_d  = err_q;
    end
    free_d = '0;
    for (int e = 0; e < CIQ_DEPTH; e++)
      if (!busy_d[e]) free_d = free_d + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      free_q <= CW'(CIQ_DEPTH);
      age_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      age_q  <= age_d;
      err_q  <= err_d;
    end
  end

  assign free_count      = free_q;
  assign iq_full         = (free_q == '0);
  assign err_double_free = err_q;
endmodule

// File: tb/tb_iq_alloc.sv
// Directed bench for iq_alloc: a free-list model checks every cycle, and literal
// expectations pin the key scenarios.

module tb_iq_alloc;
  localparam int D = 4, NI = 4, DEPTH = 16, IW = 4, AW = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [D-1:0]          dispatch_valid = '0;
  logic                  dispatch_ready;
  logic [D-1:0][IW-1:0]  free_addr;
  logic [D-1:0]          free_valid;
  logic [D-1:0][AW-1:0]  age;
  logic [NI-1:0][IW-1:0] arbit_addr = '0;
  logic [NI-1:0]         arbit_grant = '0;
  logic [IW:0]           free_count;
  logic                  iq_full;
  logic                  err_double_free;

  int checks = 0;
  int errors = 0;

  iq_alloc #(.DECODE_NUM(D), .ISSUE_NUM(NI), .CIQ_DEPTH(DEPTH), .IDX_WIDTH(IW), .AGE(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready), .free_addr(free_addr), .free_valid(free_valid),
    .age(age), .arbit_addr(arbit_addr), .arbit_grant(arbit_grant),
    .free_count(free_count), .iq_full(iq_full), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: explicit busy flags, an ascending free list and an integer age counter.
  bit mb[DEPTH];
  int mage = 0;
  bit merr = 1'b0;
  bit mok = 1'b0;
  int fq[$];
  int n, r, a;
  bit erdy;

  always @(negedge clk) begin
    fq = {};
    for (int e = 0; e < DEPTH; e++) if (!mb[e]) fq.push_back(e);
    n = $countones(dispatch_valid);
    erdy = rst_n && !flush && (n <= fq.size());
    if (mok) begin
      chk("m_ready", 32'(dispatch_ready), 32'(erdy));
      chk("m_count", 32'(free_count), fq.size());
      chk("m_full", 32'(iq_full), 32'(fq.size() == 0));
      chk("m_err", 32'(err_double_free), 32'(merr));
      r = 0;
      for (int i = 0; i < D; i++) begin
        if (dispatch_valid[i] && erdy) begin
          chk("m_fv", 32'(free_valid[i]), 1);
          chk("m_addr", 32'(free_addr[i]), fq[r]);
          chk("m_age", 32'(age[i]), (mage + r) % (1 << AW));
          r++;
        end else begin
          chk("m_fv", 32'(free_valid[i]), 0);
          chk("m_addr", 32'(free_addr[i]), 0);
          chk("m_age", 32'(age[i]), 0);
        end
      end
    end
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mb[e] = 1'b0;
      mage = 0; merr = 1'b0; mok = 1'b1;
    end else if (flush) begin
      for (int e = 0; e < DEPTH; e++) mb[e] = 1'b0;
      mage = 0;
    end else begin
      for (int j = 0; j < NI; j++)
        if (arbit_grant[j] && !mb[int'(arbit_addr[j])]) merr = 1'b1;
      for (int j = 0; j < NI; j++)
        if (arbit_grant[j]) mb[int'(arbit_addr[j])] = 1'b0;
      if (erdy) begin
        for (int k = 0; k < n; k++) mb[fq[k]] = 1'b1;
        mage = (mage + n) % (1 << AW);
      end
    end
  end

  task automatic go(input logic rs, input logic fl, input logic [3:0] dv, input logic [3:0] g,
                    input int a0, input int a1, input int a2, input int a3);
    @(posedge clk); #1;
    rst_n = rs; flush = fl; dispatch_valid = dv; arbit_grant = g;
    arbit_addr[0] = 4'(a0); arbit_addr[1] = 4'(a1);
    arbit_addr[2] = 4'(a2); arbit_addr[3] = 4'(a3);
    @(negedge clk);
  endtask

  initial begin
    go(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    go(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("rst_ready", 32'(dispatch_ready), 0);
    chk("rst_fv", 32'(free_valid), 0);
    chk("rst_count", 32'(free_count), 16);
    chk("rst_err", 32'(err_double_free), 0);

    // First allocation after reset
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("a1_fv", 32'(free_valid), 32'hF);
    chk("a1_addr", 32'(free_addr), 32'h3210);
    chk("a1_age0", 32'(age[0]), 0);
    chk("a1_age3", 32'(age[3]), 3);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("a2_count", 32'(free_count), 12);
    chk("a2_addr", 32'(free_addr), 32'h7654);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("a4_addr", 32'(free_addr), 32'hFEDC);

    // Full queue rejects a single request
    go(1, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    chk("full_flag", 32'(iq_full), 1);
    chk("full_ready", 32'(dispatch_ready), 0);
    chk("full_fv", 32'(free_valid), 0);
    chk("full_count", 32'(free_count), 0);

    // Grants 5, 9 and duplicate 5 while full
    go(1, 0, 4'b0001, 4'b0111, 5, 9, 5, 0);
    chk("gN_ready", 32'(dispatch_ready), 0);
    go(1, 0, 4'b1010, 4'b0000, 0, 0, 0, 0);
    chk("gN1_count", 32'(free_count), 2);
    chk("gN1_fv", 32'(free_valid), 32'hA);
    chk("gN1_slot1", 32'(free_addr[1]), 5);
    chk("gN1_slot3", 32'(free_addr[3]), 9);
    chk("gN1_age1", 32'(age[1]), 16);
    chk("gN1_age3", 32'(age[3]), 17);

    // Three free, four requested -> rejected; then three -> accepted
    go(1, 0, 4'b0000, 4'b0111, 0, 1, 2, 0);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("f3_count", 32'(free_count), 3);
    chk("f3_ready", 32'(dispatch_ready), 0);
    chk("f3_fv", 32'(free_valid), 0);
    go(1, 0, 4'b0111, 4'b0000, 0, 0, 0, 0);
    chk("f3b_count", 32'(free_count), 3);
    chk("f3b_ready", 32'(dispatch_ready), 1);
    chk("f3b_addr", 32'(free_addr), 32'h0210);
    chk("f3b_age2", 32'(age[2]), 20);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("f3c_count", 32'(free_count), 0);

    // Walk age_cnt up to 30 (21 -> 25 -> 29 -> 30), then wrap
    go(1, 0, 4'b0000, 4'b1111, 0, 1, 2, 3);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("w1_age0", 32'(age[0]), 21);
    go(1, 0, 4'b0000, 4'b1111, 0, 1, 2, 3);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    go(1, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);
    go(1, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    chk("w3_age0", 32'(age[0]), 29);
    go(1, 0, 4'b0000, 4'b1111, 0, 1, 2, 3);
    go(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    chk("wrap_age0", 32'(age[0]), 30);
    chk("wrap_age1", 32'(age[1]), 31);
    chk("wrap_age2", 32'(age[2]), 0);
    chk("wrap_age3", 32'(age[3]), 1);
    chk("wrap_addr", 32'(free_addr), 32'h3210);
    go(1, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);
    go(1, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    chk("wrap_next_age", 32'(age[0]), 2);

    // Flush overrides dispatch and grant; double free is sticky
    go(1, 1, 4'b1111, 4'b0001, 3, 0, 0, 0);
    chk("fl_fv", 32'(free_valid), 0);
    chk("fl_ready", 32'(dispatch_ready), 0);
    go(1, 0, 4'b0001, 4'b0001, 7, 0, 0, 0);
    chk("fl_count", 32'(free_count), 16);
    chk("fl_age", 32'(age[0]), 0);
    chk("fl_err0", 32'(err_double_free), 0);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("df_err", 32'(err_double_free), 1);
    chk("df_count", 32'(free_count), 15);
    // Grant on the free entry that is allocated the same cycle: allocation stands
    go(1, 0, 4'b0001, 4'b0001, 1, 0, 0, 0);
    chk("df2_addr", 32'(free_addr[0]), 1);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("df2_count", 32'(free_count), 14);
    go(1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("flerr_keep", 32'(err_double_free), 1);
    chk("flerr_count", 32'(free_count), 16);
    go(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("rst2_err", 32'(err_double_free), 0);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_alloc.md
IQ_ALLOC -- requirements
Module: iq_alloc

Interface
REQ-001 SHALL have parameter DECODE_NUM, default 4: rename slots offered per cycle.
REQ-002 SHALL have parameter ISSUE_NUM, default 4: arbiter grants per cycle.
REQ-003 SHALL have parameter CIQ_DEPTH, default 16: issue-queue entries.
REQ-004 SHALL have parameter IDX_WIDTH, default 4: entry index width.
REQ-005 SHALL have parameter AGE, default 5: age tag width.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-008 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-009 SHALL have port flush  input  1  pipeline flush, frees all entries.
REQ-010 SHALL have port dispatch_valid  input  DECODE_NUM  per-slot allocation request, any bit pattern.
REQ-011 SHALL have port dispatch_ready  output  1  all requested slots accepted this cycle.
REQ-012 SHALL have port free_addr  output  DECODE_NUM x IDX_WIDTH  entry assigned per slot.
REQ-013 SHALL have port free_valid  output  DECODE_NUM  free_addr[i] is a real allocation, queue writes it.
REQ-014 SHALL have port age  output  DECODE_NUM x AGE  age tag per slot.
REQ-015 SHALL have port arbit_addr  input  ISSUE_NUM x IDX_WIDTH  entries selected for issue.
REQ-016 SHALL have port arbit_grant  input  ISSUE_NUM  arbit_addr[j] valid; entry is released.
REQ-017 SHALL have port free_count  output  IDX_WIDTH+1  registered number of free entries, 0..CIQ_DEPTH.
REQ-018 SHALL have port iq_full  output  1  free_count == 0.
REQ-019 SHALL have port err_double_free  output  1  sticky: grant hit an already-free entry.

Function
REQ-020 SHALL hold a CIQ_DEPTH-bit busy vector, a free_count register and an AGE-bit age counter age_cnt.
REQ-021 SHALL compute N = popcount(dispatch_valid); dispatch_ready = (N <= free_count) && !flush && rst_n; allocation is all-or-nothing.
REQ-022 SHALL, when accepted, give slot i (dispatch_valid[i]=1) with rank r (number of set dispatch_valid bits below i) the r-th lowest-index free entry; free_valid[i] = dispatch_valid[i] & dispatch_ready.
REQ-023 SHALL drive free_addr, free_valid, age combinationally from current state (zero-cycle latency); unassigned slots drive free_addr=0, age=0.
REQ-024 SHALL give age[i] = (age_cnt + r) mod 2^AGE; at the edge age_cnt advances by N if accepted, wrapping mod 2^AGE.
REQ-025 SHALL set allocated entries busy at the clock edge; free_count counts busy state at cycle start only.
REQ-026 SHALL clear busy for each granted arbit_addr at the edge; freed entries become allocatable the following cycle (no same-cycle bypass).
REQ-027 SHALL treat duplicate grant addresses in one cycle as a single release.
REQ-028 SHALL set err_double_free when a grant targets an entry not busy at cycle start; that entry's allocation in the same cycle still stands.
REQ-029 SHALL update free_count = free_count - allocated + distinct valid releases, saturating never required (invariant 0..CIQ_DEPTH).
REQ-030 SHALL, on flush, clear the busy vector, set free_count=CIQ_DEPTH, age_cnt=0; flush overrides same-cycle dispatch and grants; err_double_free unchanged.

Reset
REQ-031 SHALL, while rst_n=0 at an edge, set busy vector all 0, free_count=CIQ_DEPTH, age_cnt=0, err_double_free=0.
REQ-032 SHALL drive dispatch_ready=0 and free_valid=0 while rst_n=0; reset overrides flush, dispatch and grants.

Verification
REQ-033 SHALL cover: after reset, dispatch_valid=4'b1111 -> free_addr 0,1,2,3, free_valid=4'b1111, age 0,1,2,3; next cycle free_count=12.
REQ-034 SHALL cover: four accepted 4'b1111 cycles then dispatch_valid=4'b0001 -> iq_full=1, dispatch_ready=0, free_valid=0, free_count stays 0.
REQ-035 SHALL cover: full queue, cycle N grants 5 and 9 (plus duplicate 5) -> N: dispatch_ready=0; N+1: free_count=2, dispatch_valid=4'b1010 -> slot1=5, slot3=9.
REQ-036 SHALL cover: free_count=3, dispatch_valid=4'b1111 -> rejected, no state change; then 4'b0111 -> accepted, free_count=0.
REQ-037 SHALL cover: age_cnt=30, accept 4 -> ages 30,31,0,1, age_cnt=2 next cycle.
REQ-038 SHALL cover: flush with dispatch_valid=4'b1111 and grant valid -> free_valid=0; next cycle free_count=16, age_cnt=0; grant to free entry 7 -> err_double_free=1 until rst_n=0.
